// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 scan timing (DrawX/DrawY, blank, hs, vs) with
// ce-qualified advance and PIPE_DELAY-deep delayed copies of blank/hs/vs.
// Optional macro VGA_FRAME_CNT_EN adds an 8-bit frame counter output.
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIPE_DELAY = 2
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       ce,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       frame_start,
  output logic       line_end,
  output logic       blank_d,
  output logic       hs_d,
  output logic       vs_d
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [7:0] frame_cnt
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  // Decode thresholds are 11 bits so a 1024-wide region still compares correctly.
  localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] H_SYNC_END = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] V_SYNC_END = 11'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end
  if (PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_bad_delay
    $error("vga_timing_gen: PIPE_DELAY must be in 0..7");
  end

  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic [10:0] h_ext;
  logic [10:0] v_ext;
  logic        vis_nxt;
  logic        hs_nxt;
  logic        vs_nxt;

  assign h_ext = {1'b0, h_cnt};
  assign v_ext = {1'b0, v_cnt};

  // Combinational decode of the counter position feeding the output register.
  always_comb begin
    vis_nxt = (h_ext < H_VIS_END) && (v_ext < V_VIS_END);
    hs_nxt  = !((h_ext >= H_SYNC_BEG) && (h_ext < H_SYNC_END));
    vs_nxt  = !((v_ext >= V_SYNC_BEG) && (v_ext < V_SYNC_END));
  end

  // Scan position counters: h wraps every line, v wraps with the last pixel of a frame.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (ce) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  // Output register: position and all decodes captured together so they never disagree.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      DrawX       <= '0;
      DrawY       <= '0;
      blank       <= 1'b0;
      hs          <= 1'b1;
      vs          <= 1'b1;
      frame_start <= 1'b0;
      line_end    <= 1'b0;
    end else if (ce) begin
      DrawX       <= h_cnt;
      DrawY       <= v_cnt;
      blank       <= vis_nxt;
      hs          <= hs_nxt;
      vs          <= vs_nxt;
      frame_start <= (h_cnt == 10'd0) && (v_cnt == 10'd0);
      line_end    <= (h_cnt == H_LAST);
    end
  end

  if (PIPE_DELAY == 0) begin : g_no_delay
    assign blank_d = blank;
    assign hs_d    = hs;
    assign vs_d    = vs;
  end else begin : g_delay
    // Bit 0 holds the newest sample; the top bit is the delayed output.
    logic [PIPE_DELAY-1:0] blank_sr;
    logic [PIPE_DELAY-1:0] hs_sr;
    logic [PIPE_DELAY-1:0] vs_sr;

    // Delay lines shift on ce and hold otherwise; reset loads idle (blanked, syncs high).
    always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
        blank_sr <= '0;
        hs_sr    <= '1;
        vs_sr    <= '1;
      end else if (ce) begin
        blank_sr <= PIPE_DELAY'({blank_sr, blank});
        hs_sr    <= PIPE_DELAY'({hs_sr, hs});
        vs_sr    <= PIPE_DELAY'({vs_sr, vs});
      end
    end

    assign blank_d = blank_sr[PIPE_DELAY-1];
    assign hs_d    = hs_sr[PIPE_DELAY-1];
    assign vs_d    = vs_sr[PIPE_DELAY-1];
  end

`ifdef VGA_FRAME_CNT_EN
  // Count entries into (0,0); the (0,0) right after reset is not an entry because
  // the output register already sits at (0,0).
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      frame_cnt <= '0;
    end else if (ce && (h_cnt == 10'd0) && (v_cnt == 10'd0) &&
                 !((DrawX == 10'd0) && (DrawY == 10'd0))) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen using a reduced raster so full frames
// stay short. Expected outputs are derived from the count of ce edges since reset.
module tb_vga_timing_gen;

  localparam int HV = 8, HFP = 2, HS = 3, HBP = 3;
  localparam int VV = 6, VFP = 1, VS = 2, VBP = 2;
  localparam int HT = HV + HFP + HS + HBP;
  localparam int VT = VV + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam int D = 2;

  logic       vga_clk;
  logic       reset_n;
  logic       ce;
  logic [9:0] DrawX, DrawY;
  logic       blank, hs, vs, frame_start, line_end;
  logic       blank_d, hs_d, vs_d;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0] frame_cnt;
`endif

  int total = 0;
  int bad = 0;
  int k = 0;  // ce edges since the last reset

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       b;
    logic       h;
    logic       v;
    logic       fs;
    logic       le;
  } exp_t;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .PIPE_DELAY(D)
  ) dut (
    .vga_clk(vga_clk),
    .reset_n(reset_n),
    .ce(ce),
    .DrawX(DrawX),
    .DrawY(DrawY),
    .blank(blank),
    .hs(hs),
    .vs(vs),
    .frame_start(frame_start),
    .line_end(line_end),
    .blank_d(blank_d),
    .hs_d(hs_d),
    .vs_d(vs_d)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_cnt(frame_cnt)
`endif
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL %s k=%0d got=%0h want=%0h", tag, k, obs, want);
    end
  endtask

  // Outputs after the j-th ce edge following reset; j<=0 means reset values.
  function automatic exp_t exp_at(input int j);
    exp_t e;
    int p, x, y;
    e = '0;
    e.h = 1'b1;
    e.v = 1'b1;
    if (j > 0) begin
      p = (j - 1) % FRAME;
      x = p % HT;
      y = p / HT;
      e.x  = 10'(x);
      e.y  = 10'(y);
      e.b  = (x < HV) && (y < VV);
      e.h  = !((x >= HV + HFP) && (x < HV + HFP + HS));
      e.v  = !((y >= VV + VFP) && (y < VV + VFP + VS));
      e.fs = (p == 0);
      e.le = (x == HT - 1);
    end
    return e;
  endfunction

  task automatic check_all();
    exp_t e, ed;
    e  = exp_at(k);
    ed = exp_at(k - D);
    check_val("x", 32'(DrawX), 32'(e.x));
    check_val("y", 32'(DrawY), 32'(e.y));
    check_val("blank", 32'(blank), 32'(e.b));
    check_val("hs", 32'(hs), 32'(e.h));
    check_val("vs", 32'(vs), 32'(e.v));
    check_val("frame_start", 32'(frame_start), 32'(e.fs));
    check_val("line_end", 32'(line_end), 32'(e.le));
    check_val("blank_d", 32'(blank_d), 32'(ed.b));
    check_val("hs_d", 32'(hs_d), 32'(ed.h));
    check_val("vs_d", 32'(vs_d), 32'(ed.v));
`ifdef VGA_FRAME_CNT_EN
    check_val("frame_cnt", 32'(frame_cnt), (k > 0) ? 32'(((k - 1) / FRAME) % 256) : 32'd0);
`endif
  endtask

  // One clock: drive inputs, update the model at the edge, check at the falling edge.
  task automatic step(input logic r, input logic c);
    reset_n = r;
    ce = c;
    @(posedge vga_clk);
    if (!r) k = 0;
    else if (c) k++;
    @(negedge vga_clk);
    check_all();
  endtask

  int n_blank, n_hs_lo, n_vs_lo;
  bit found;

  initial begin
    reset_n = 1'b0;
    ce = 1'b1;
    @(negedge vga_clk);

    // Reset held with ce high, then release.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    check_val("rst_hs_d", 32'(hs_d), 32'd1);
    step(1'b1, 1'b1);
    check_val("first_fs", 32'(frame_start), 32'd1);
    check_val("first_blank", 32'(blank), 32'd1);

    // Two free-running frames from a fresh reset, with aggregate counts.
    step(1'b0, 1'b1);
    n_blank = 0; n_hs_lo = 0; n_vs_lo = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step(1'b1, 1'b1);
      if (k == 2) check_val("blank_d_k2", 32'(blank_d), 32'd0);
      if (k == 3) check_val("blank_d_k3", 32'(blank_d), 32'd1);
      n_blank += int'(blank);
      n_hs_lo += int'(!hs);
      n_vs_lo += int'(!vs);
    end
    check_val("blank_cnt", 32'(n_blank), 32'(2 * HV * VV));
    check_val("hs_lo_cnt", 32'(n_hs_lo), 32'(2 * HS * VT));
    check_val("vs_lo_cnt", 32'(n_vs_lo), 32'(2 * VS * HT));
    step(1'b1, 1'b1);
    check_val("frame_period", 32'(frame_start), 32'd1);

    // Alternating ce, as when clocked at twice the pixel rate.
    for (int i = 0; i < 4 * FRAME; i++) step(1'b1, (i % 2) == 0);

    // Reset in the middle of an hsync pulse.
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      step(1'b1, 1'b1);
      if (DrawX == 10'(HV + HFP + 1) && DrawY == 10'd3) found = 1'b1;
    end
    check_val("find_hsync", 32'(found), 32'd1);
    check_val("in_hsync", 32'(hs), 32'd0);
    step(1'b0, 1'b1);
    check_val("mid_rst_hs", 32'(hs), 32'd1);
    step(1'b1, 1'b0);
    check_val("no_spurious_fs", 32'(frame_start), 32'd0);
    step(1'b1, 1'b1);
    check_val("restart_fs", 32'(frame_start), 32'd1);

    // Random ce with occasional reset pulses.
    for (int i = 0; i < 3000; i++)
      step(($urandom % 400) != 0, ($urandom % 3) != 0);

`ifdef VGA_FRAME_CNT_EN
    step(1'b0, 1'b1);
    for (int i = 0; i < 3 * FRAME + 1; i++) step(1'b1, 1'b1);
    check_val("fcnt_3", 32'(frame_cnt), 32'd3);
    for (int i = 0; i < 256 * FRAME; i++) step(1'b1, 1'b1);
    check_val("fcnt_wrap", 32'(frame_cnt), 32'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
